// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the iterative sequential multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Iteration counter width: enough bits to hold 0 .. WIDTH/BPC-1, never zero bits wide.
    function automatic int cnt_w(input int width, input int bpc);
        int n;
        n = width / bpc;
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int width, input int bpc);
        return (width >= 2) && ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One radix-2^BPC partial-product step: acc + ((mcand * digit) << (BPC * idx)).
module mult_pp_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1,
    parameter int CNT_W = 3
) (
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [BPC-1:0]     i_digit,
    input  logic [CNT_W-1:0]   i_idx,
    input  logic [2*WIDTH-1:0] i_acc,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] w_pp;
    logic [2*WIDTH-1:0] w_pp_shifted;
    logic [31:0]        w_shamt;

    // The product is formed at full result width so the top digit never loses carries.
    assign w_pp         = (2*WIDTH)'(i_mcand) * (2*WIDTH)'(i_digit);
    assign w_shamt      = 32'(i_idx) * 32'(BPC);
    assign w_pp_shifted = w_pp << w_shamt;
    assign o_acc        = i_acc + w_pp_shifted;

endmodule

// File: rtl/mult_seq_iter.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier, BPC multiplier bits per cycle, with
// valid/ready handshakes and per-operation signed/unsigned mode (sign-magnitude internally).
module mult_seq_iter
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    localparam int  N         = WIDTH / BPC;
    localparam int  CNT_W     = cnt_w(WIDTH, BPC);
    localparam bit  PARAMS_OK = params_ok(WIDTH, BPC);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("mult_seq_iter: BPC must be 1, 2 or 4 and divide WIDTH (WIDTH >= 2)");
        end
    endgenerate

    mult_state_t        r_state;
    mult_state_t        w_next_state;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_release;
    logic               w_last;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_result;

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign P         = r_p;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_release = r_out_valid && out_ready;
    assign w_last    = (r_state == RUN) && (r_cnt == CNT_W'(N - 1));

    // Magnitudes as unsigned WIDTH bits: -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
    assign w_a_mag  = (is_signed && A[WIDTH-1]) ? (-A) : A;
    assign w_b_mag  = (is_signed && B[WIDTH-1]) ? (-B) : B;
    assign w_neg    = is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
    assign w_result = r_neg ? (-w_acc_next) : w_acc_next;

    mult_pp_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC),
        .CNT_W (CNT_W)
    ) u_pp_step (
        .i_mcand (r_mcand),
        .i_digit (r_mplier[BPC-1:0]),
        .i_idx   (r_cnt),
        .i_acc   (r_acc),
        .o_acc   (w_acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept)  w_next_state = RUN;
            RUN:  if (w_last)    w_next_state = DONE;
            DONE: if (w_release) w_next_state = IDLE;
            default:             w_next_state = IDLE;
        endcase
    end

    // Operand and accumulator registers: loaded on accept, stepped once per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= w_neg;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> BPC;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // P only ever changes on the final iteration, so a partial product is never visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p         <= '0;
            r_out_valid <= 1'b0;
        end else if (w_last) begin
            r_p         <= w_result;
            r_out_valid <= 1'b1;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
